cpu_bus_responder: RTL and testbench

- Target side of the 8-bit CPU bus. Answers the pipelined CPU initiator: it samples `address_next`, `write_next` and `data_o_next`, and drives `data_i` and `ready`.
- Contains a synchronous byte RAM and a 16-byte I/O register window.
- Inserts programmable wait states per region by holding `ready` low.
- Sits between the CPU core and on-chip memory; also used as the bench memory model for core verification.

---
 rtl/cpu_bus_responder.sv | 192 +++++++++++++++++++
 tb/tb_cpu_bus_responder.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: target side of the pipelined 8-bit CPU bus.
// Byte RAM, 16-byte I/O window, per-region wait states.
// Ports: clk, reset (async, active-low), address_next/write_next/
//   data_o_next (next-cycle request), sync (fetch flag of current
//   cycle), ready (cycle completes at next edge), data_i (read
//   data), ram_we (RAM write commits at next edge).
module cpu_bus_responder #(
  parameter int          ADDR_W   = 14,
  parameter logic [15:0] IO_BASE  = 16'hD000,
  parameter logic [3:0]  RAM_WAIT = 4'd0,
  parameter logic [3:0]  IO_WAIT  = 4'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address_next,
  input  logic        write_next,
  input  logic [7:0]  data_o_next,
  input  logic        sync,
  output logic        ready,
  output logic [7:0]  data_i,
  output logic        ram_we
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [3:0] OFF_SCR = 4'h0;
  localparam logic [3:0] OFF_CFG = 4'h1;
  localparam logic [3:0] OFF_CLO = 4'h2;
  localparam logic [3:0] OFF_CHI = 4'h3;
  localparam logic [3:0] OFF_FET = 4'h4;

  typedef enum logic {
    S_ACCEPT,
    S_WAIT
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] idx;
    logic              we;
    logic [7:0]        wd;
    logic              io;
  } bus_cyc_t;

  state_t     state;
  bus_cyc_t   cur;
  bus_cyc_t   nxt;
  logic       pend;
  logic [3:0] cnt;

  logic [7:0] mem [DEPTH];

  logic [7:0]  scratch;
  logic [7:0]  waitcfg;
  logic [7:0]  fetch;
  logic [7:0]  cyc_sh;
  logic [15:0] cyc;

  logic        done;
  logic        wr_ram;
  logic        wr_io;
  logic        rd_cap;
  logic [3:0]  n_wait;
  logic [3:0]  off_w;
  logic [3:0]  off_r;

  logic [7:0]  scratch_n;
  logic [7:0]  waitcfg_n;
  logic [7:0]  fetch_n;
  logic [7:0]  sh_w;
  logic [7:0]  sh_n;
  logic [15:0] cyc_n;

  logic [7:0]  io_rd;
  logic [7:0]  ram_rd;

  always_comb begin
    nxt.idx = address_next[ADDR_W-1:0];
    nxt.we  = write_next;
    nxt.wd  = data_o_next;
    nxt.io  = address_next[15:4] == IO_BASE[15:4];
  end

  // pend stays low only until the first capture after reset
  assign done   = (state == S_ACCEPT) && pend;
  assign wr_ram = done && cur.we && !cur.io;
  assign wr_io  = done && cur.we && cur.io;
  assign rd_cap = (state == S_ACCEPT) && !write_next;
  assign ram_we = wr_ram;

  assign off_w  = cur.idx[3:0];
  assign off_r  = address_next[3:0];

  // wait count comes from the pre-edge WAITCFG
  assign n_wait = nxt.io ? waitcfg[7:4] : waitcfg[3:0];

  // Register next-state; a clear-by-write beats an increment.
  always_comb begin
    scratch_n = scratch;
    waitcfg_n = waitcfg;
    cyc_n     = cyc + 16'd1;
    sh_w      = cyc_sh;
    fetch_n   = fetch + {7'd0, done & sync};
    if (wr_io) begin
      unique case (1'b1)
        off_w == OFF_SCR: scratch_n = cur.wd;
        off_w == OFF_CFG: waitcfg_n = cur.wd;
        off_w == OFF_CLO: begin
          cyc_n = '0;
          sh_w  = '0;
        end
        off_w == OFF_FET: fetch_n = '0;
        default: ;
      endcase
    end
    sh_n = sh_w;
    if (rd_cap && nxt.io && off_r == OFF_CLO)
      sh_n = cyc_n[15:8];
  end

  // I/O reads see the post-edge register values (write-first)
  always_comb begin
    io_rd = 8'hFF;
    unique case (1'b1)
      off_r == OFF_SCR: io_rd = scratch_n;
      off_r == OFF_CFG: io_rd = waitcfg_n;
      off_r == OFF_CLO: io_rd = cyc_n[7:0];
      off_r == OFF_CHI: io_rd = sh_w;
      off_r == OFF_FET: io_rd = fetch_n;
      default: ;
    endcase
  end

  assign ram_rd = (wr_ram && cur.idx == nxt.idx) ?
                  cur.wd : mem[nxt.idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_ACCEPT;
      ready  <= 1'b1;
      pend   <= 1'b0;
      cur    <= '0;
      cnt    <= '0;
      data_i <= '0;
    end else begin
      unique case (state)
        S_ACCEPT: begin
          pend <= 1'b1;
          cur  <= nxt;
          cnt  <= n_wait;
          if (rd_cap)
            data_i <= nxt.io ? io_rd : ram_rd;
          if (n_wait == 4'd0) begin
            state <= S_ACCEPT;
            ready <= 1'b1;
          end else begin
            state <= S_WAIT;
            ready <= 1'b0;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= S_ACCEPT;
            ready <= 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scratch <= '0;
      waitcfg <= {IO_WAIT, RAM_WAIT};
      cyc     <= '0;
      cyc_sh  <= '0;
      fetch   <= '0;
    end else begin
      scratch <= scratch_n;
      waitcfg <= waitcfg_n;
      cyc     <= cyc_n;
      cyc_sh  <= sh_n;
      fetch   <= fetch_n;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ram)
      mem[cur.idx] <= cur.wd;
  end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// tb_cpu_bus_responder: directed bench for cpu_bus_responder.
// Drives bus cycles at negedges, samples at negedges.
module tb_cpu_bus_responder;

  localparam logic [15:0] IOB = 16'hD000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] address_next = 16'h0000;
  logic        write_next = 1'b0;
  logic [7:0]  data_o_next = 8'h00;
  logic        sync = 1'b0;
  logic        ready;
  logic [7:0]  data_i;
  logic        ram_we;

  int tests = 0;
  int fails = 0;
  int we_cnt = 0;

  logic [7:0] rd;
  int         lows;
  logic       st;

  cpu_bus_responder dut (
    .clk(clk),
    .reset(reset),
    .address_next(address_next),
    .write_next(write_next),
    .data_o_next(data_o_next),
    .sync(sync),
    .ready(ready),
    .data_i(data_i),
    .ram_we(ram_we)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (ram_we === 1'b1) we_cnt++;

  // Entry: at a negedge with ready==1. Exit: at the negedge
  // before the completion edge of this cycle.
  task automatic bus(
    input  logic [15:0] a,
    input  logic        w,
    input  logic [7:0]  d,
    input  logic        sy,
    output logic [7:0]  rdv,
    output int          nlow,
    output logic        stab
  );
    logic [7:0] first;
    logic       fin;
    address_next = a;
    write_next = w;
    data_o_next = d;
    @(posedge clk);
    #1;
    sync = sy;
    address_next = 16'h0000;
    write_next = 1'b0;
    data_o_next = 8'h00;
    nlow = 0;
    stab = 1'b1;
    fin = 1'b0;
    first = 8'h00;
    for (int k = 0; k < 40 && !fin; k++) begin
      @(negedge clk);
      if (k == 0) first = data_i;
      else if (data_i !== first) stab = 1'b0;
      if (ready === 1'b1) fin = 1'b1;
      else nlow++;
    end
    rdv = data_i;
    if (!fin) begin
      tests++;
      fails++;
      $display("FAIL bus_timeout addr=%h", a);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready got=%b exp=1", ready);
    end
    tests++;
    if (data_i !== 8'h00) begin
      fails++;
      $display("FAIL reset_data got=%h exp=00", data_i);
    end
    tests++;
    if (ram_we !== 1'b0) begin
      fails++;
      $display("FAIL reset_ram_we got=%b exp=0", ram_we);
    end
    reset = 1'b1;
    bus(IOB + 16'h1, 1'b0, 8'h00, 1'b0, rd, lows, st);
    tests++;
    if (rd !== 8'h10) begin
      fails++;
      $display("FAIL reset_waitcfg got=%h exp=10", rd);
    end
    tests++;
    if (lows !== 1) begin
      fails++;
      $display("FAIL io_wait1 got=%0d exp=1", lows);
    end
    bus(IOB, 1'b1, 8'hC3, 1'b0, rd, lows, st);
    bus(IOB, 1'b0, 8'h00, 1'b0, rd, lows, st);
    tests++;
    if (rd !== 8'hC3) begin
      fails++;
      $display("FAIL scratch_rw got=%h exp=c3", rd);
    end
  endtask

  task automatic test_ram_rw();
    int we0;
    we0 = we_cnt;
    bus(16'h0123, 1'b1, 8'h5A, 1'b0, rd, lows, st);
    tests++;
    if (lows !== 0) begin
      fails++;
      $display("FAIL ram_wr_wait got=%0d exp=0", lows);
    end
    bus(16'h0123, 1'b0, 8'h00, 1'b0, rd, lows, st);
    tests++;
    if (rd !== 8'h5A) begin
      fails++;
      $display("FAIL ram_rd_bypass got=%h exp=5a", rd);
    end
    tests++;
    if (lows !== 0) begin
      fails++;
      $display("FAIL ram_rd_wait got=%0d exp=0", lows);
    end
    bus(16'h0000, 1'b0, 8'h00, 1'b0, rd, lows, st);
    tests++;
    if (we_cnt - we0 !== 1) begin
      fails++;
      $display("FAIL ram_we_pulses got=%0d exp=1", we_cnt - we0);
    end
  endtask

  task automatic test_waitcfg();
    bus(IOB + 16'h1, 1'b1, 8'h33, 1'b0, rd, lows, st);
    tests++;
    if (lows !== 1) begin
      fails++;
      $display("FAIL cfg_wr_wait got=%0d exp=1", lows);
    end
    bus(16'h0000, 1'b0, 8'h00, 1'b0, rd, lows, st);
    tests++;
    if (lows !== 0) begin
      fails++;
      $display("FAIL cfg_old_value got=%0d exp=0", lows);
    end
    bus(16'h0123, 1'b0, 8'h00, 1'b0, rd, lows, st);
    tests++;
    if (lows !== 3) begin
      fails++;
      $display("FAIL ram_wait3 got=%0d exp=3", lows);
    end
    tests++;
    if (rd !== 8'h5A || st !== 1'b1) begin
      fails++;
      $display("FAIL ram_hold got=%h/%b exp=5a/1", rd, st);
    end
    bus(IOB + 16'h1, 1'b0, 8'h00, 1'b0, rd, lows, st);
    tests++;
    if (rd !== 8'h33 || lows !== 3) begin
      fails++;
      $display("FAIL cfg_rd got=%h/%0d exp=33/3", rd, lows);
    end
    bus(IOB + 16'h1, 1'b1, 8'h10, 1'b0, rd, lows, st);
    bus(16'h0000, 1'b0, 8'h00, 1'b0, rd, lows, st);
  endtask

  task automatic test_alias();
    bus(16'h4010, 1'b1, 8'hA5, 1'b0, rd, lows, st);
    bus(16'h0000, 1'b0, 8'h00, 1'b0, rd, lows, st);
    bus(16'h0010, 1'b0, 8'h00, 1'b0, rd, lows, st);
    tests++;
    if (rd !== 8'hA5) begin
      fails++;
      $display("FAIL alias_0010 got=%h exp=a5", rd);
    end
    bus(16'hC010, 1'b0, 8'h00, 1'b0, rd, lows, st);
    tests++;
    if (rd !== 8'hA5) begin
      fails++;
      $display("FAIL alias_c010 got=%h exp=a5", rd);
    end
  endtask

  task automatic test_cyc();
    logic [7:0] lo;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (300) @(negedge clk);
    // capture edge is the 301st since release
    bus(IOB + 16'h2, 1'b0, 8'h00, 1'b0, lo, lows, st);
    tests++;
    if (lo !== 8'h2D) begin
      fails++;
      $display("FAIL cyc_lo got=%h exp=2d", lo);
    end
    bus(IOB + 16'h3, 1'b0, 8'h00, 1'b0, rd, lows, st);
    tests++;
    if (rd !== 8'h01) begin
      fails++;
      $display("FAIL cyc_hi got=%h exp=01", rd);
    end
  endtask

  task automatic test_fetch();
    bus(IOB + 16'h4, 1'b1, 8'h00, 1'b0, rd, lows, st);
    for (int i = 0; i < 3; i++)
      bus(16'h0100 + 16'(i), 1'b0, 8'h00, 1'b1, rd, lows, st);
    bus(IOB + 16'h4, 1'b0, 8'h00, 1'b0, rd, lows, st);
    tests++;
    if (rd !== 8'h03) begin
      fails++;
      $display("FAIL fetch_3 got=%h exp=03", rd);
    end
    for (int i = 0; i < 253; i++)
      bus(16'h0100 + 16'(i), 1'b0, 8'h00, 1'b1, rd, lows, st);
    bus(IOB + 16'h4, 1'b0, 8'h00, 1'b0, rd, lows, st);
    tests++;
    if (rd !== 8'h00) begin
      fails++;
      $display("FAIL fetch_wrap got=%h exp=00", rd);
    end
    for (int i = 0; i < 2; i++)
      bus(16'h0200, 1'b0, 8'h00, 1'b1, rd, lows, st);
    bus(IOB + 16'h4, 1'b1, 8'h77, 1'b1, rd, lows, st);
    bus(IOB + 16'h4, 1'b0, 8'h00, 1'b0, rd, lows, st);
    tests++;
    if (rd !== 8'h00) begin
      fails++;
      $display("FAIL fetch_clear got=%h exp=00", rd);
    end
    bus(IOB + 16'h9, 1'b0, 8'h00, 1'b0, rd, lows, st);
    tests++;
    if (rd !== 8'hFF || lows !== 1) begin
      fails++;
      $display("FAIL io_unused got=%h/%0d exp=ff/1", rd, lows);
    end
  endtask

  task automatic test_reset_mid();
    bus(16'h0200, 1'b1, 8'h11, 1'b0, rd, lows, st);
    bus(IOB + 16'h1, 1'b1, 8'h33, 1'b0, rd, lows, st);
    bus(16'h0000, 1'b0, 8'h00, 1'b0, rd, lows, st);
    address_next = 16'h0200;
    write_next = 1'b1;
    data_o_next = 8'hEE;
    @(posedge clk);
    #1;
    address_next = 16'h0000;
    write_next = 1'b0;
    data_o_next = 8'h00;
    repeat (2) @(negedge clk);
    tests++;
    if (ready !== 1'b0) begin
      fails++;
      $display("FAIL mid_waiting got=%b exp=0", ready);
    end
    #2;
    reset = 1'b0;
    #1;
    tests++;
    if (ready !== 1'b1 || ram_we !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset got=%b/%b exp=1/0", ready, ram_we);
    end
    @(negedge clk);
    reset = 1'b1;
    bus(16'h0200, 1'b0, 8'h00, 1'b0, rd, lows, st);
    tests++;
    if (rd !== 8'h11) begin
      fails++;
      $display("FAIL mid_ram got=%h exp=11", rd);
    end
    bus(IOB + 16'h1, 1'b0, 8'h00, 1'b0, rd, lows, st);
    tests++;
    if (rd !== 8'h10 || lows !== 1) begin
      fails++;
      $display("FAIL mid_cfg got=%h/%0d exp=10/1", rd, lows);
    end
  endtask

  initial begin
    test_reset();
    test_ram_rw();
    test_waitcfg();
    test_alias();
    test_cyc();
    test_fetch();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
